// File: rtl/cluster_count_pkg.sv
// Shared sizing helpers for the pipelined VPF counter.
// Every derived width and depth is computed here, so the top and the tree levels use the same numbers.
package cluster_count_pkg;

    // Widest group the popcount helper accepts.
    localparam int MAX_GROUP = 32;

    // Ceiling log2. clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Number of first-stage popcount groups.
    // The last group is zero-padded when NVPF is not a multiple of GROUP.
    function automatic int ngroup_of(input int nvpf, input int group);
        return (nvpf + group - 1) / group;
    endfunction

    // Width of a count that can hold values from 0 to nvpf.
    function automatic int cnt_w_of(input int nvpf);
        return clog2(nvpf + 1);
    endfunction

    // Number of binary adder-tree levels.
    function automatic int levels_of(input int nvpf, input int group);
        return clog2(ngroup_of(nvpf, group));
    endfunction

    // Input register + group popcount + tree levels + output register.
    function automatic int lat_of(input int nvpf, input int group);
        return 3 + levels_of(nvpf, group);
    endfunction

    // Node count entering tree level k. Each level halves the count, rounding up.
    function automatic int nodes_at(input int n, input int k);
        int m;
        m = n;
        for (int i = 0; i < k; i++) m = (m + 1) / 2;
        return m;
    endfunction

    // Population count of one group, zero-extended to MAX_GROUP bits.
    function automatic logic [5:0] count1s(input logic [MAX_GROUP-1:0] bits);
        logic [5:0] total;
        total = '0;
        for (int i = 0; i < MAX_GROUP; i++) total = total + {5'd0, bits[i]};
        return total;
    endfunction

    // Values for the default 1536-pad configuration.
    localparam int NGROUP_DEFAULT = ngroup_of(1536, 6);
    localparam int CNT_W_DEFAULT  = cnt_w_of(1536);
    localparam int LAT_DEFAULT    = lat_of(1536, 6);

endpackage

// File: rtl/cluster_add_level.sv
// One registered level of the binary adder tree.
// Adjacent pairs are summed into results that are one bit wider.
// An odd last node is paired with zero, so it passes through one register unchanged and every path keeps the same depth.
module cluster_add_level
    import cluster_count_pkg::*;
#(
    parameter  int N_IN  = 2,
    parameter  int W_IN  = 3,
    localparam int N_OUT = (N_IN + 1) / 2,
    localparam int W_OUT = W_IN + 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_IN*W_IN-1:0]     din,
    output logic [N_OUT*W_OUT-1:0]   dout
);

    localparam int PAD_W = 2 * N_OUT * W_IN;

    logic [PAD_W-1:0] din_pad;

    assign din_pad = PAD_W'(din);

    // Pairwise sums, one register per level.
    // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values whatever the statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                dout[i*W_OUT +: W_OUT] <= W_OUT'(din_pad[(2*i)*W_IN +: W_IN])
                                        + W_OUT'(din_pad[(2*i+1)*W_IN +: W_IN]);
            end
        end
    end

endmodule

// File: rtl/cluster_count_pipe.sv
// Pipelined count of valid cluster-finder pads per bunch crossing.
// The datapath is input register -> group popcount -> adder tree -> output register, with a valid bit travelling alongside.
// Monitoring logic adds an overflow flag, a peak hold and a saturating overflow tally.
module cluster_count_pipe
    import cluster_count_pkg::*;
#(
    parameter  int NVPF     = 1536,
    parameter  int GROUP    = 6,
    parameter  int THRESH_W = 11,
    parameter  int OVFCNT_W = 16,
    localparam int CNT_W    = cnt_w_of(NVPF)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NVPF-1:0]     vpfs_i,
    input  logic                valid_i,
    input  logic [THRESH_W-1:0] thresh_i,
    input  logic                clr_i,
    output logic [CNT_W-1:0]    cnt_o,
    output logic                valid_o,
    output logic                overflow_o,
    output logic [CNT_W-1:0]    peak_o,
    output logic [OVFCNT_W-1:0] ovf_cnt_o
);

    localparam int NGROUP = ngroup_of(NVPF, GROUP);
    localparam int L      = levels_of(NVPF, GROUP);
    localparam int GW     = clog2(GROUP + 1);
    localparam int TW     = GW + L;
    localparam int PAD_W  = NGROUP * GROUP;
    localparam int CMP_W  = (TW > THRESH_W) ? TW : THRESH_W;

    // Keep these as private copies; the cluster finder registers the same inputs.
    (* equivalent_register_removal = "no", shreg_extract = "no" *) logic [NVPF-1:0] vpfs_q;
    (* equivalent_register_removal = "no", shreg_extract = "no" *) logic            valid_q;

    logic [PAD_W-1:0]     vpfs_pad;
    logic [NGROUP*GW-1:0] grp_cnt;
    logic [L:0]           vld_sr;
    logic [TW-1:0]        tree_full;
    logic                 ovf_hit;

    // Input register for the pad vector and its qualifier.
    // NOTE: the wide data registers are reset as well, so a mid-stream reset leaves no stale counts in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vpfs_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            vpfs_q  <= vpfs_i;
            valid_q <= valid_i;
        end
    end

    assign vpfs_pad = PAD_W'(vpfs_q);

    // First stage: popcount of each GROUP-bit slice.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grp_cnt <= '0;
        end else begin
            for (int g = 0; g < NGROUP; g++) begin
                grp_cnt[g*GW +: GW] <= GW'(count1s(MAX_GROUP'(vpfs_pad[g*GROUP +: GROUP])));
            end
        end
    end

    // Adder tree. Level k takes nodes_at(NGROUP, k) inputs that are GW+k bits wide.
    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int N_IN  = nodes_at(NGROUP, k);
        localparam int N_OUT = nodes_at(NGROUP, k + 1);
        localparam int W_IN  = GW + k;

        logic [N_OUT*(W_IN+1)-1:0] sum;

        if (k == 0) begin : g_head
            cluster_add_level #(.N_IN(N_IN), .W_IN(W_IN)) u_add (
                .clock  (clock),
                .reset_n(reset_n),
                .din    (grp_cnt),
                .dout   (sum)
            );
        end else begin : g_body
            cluster_add_level #(.N_IN(N_IN), .W_IN(W_IN)) u_add (
                .clock  (clock),
                .reset_n(reset_n),
                .din    (g_lvl[k-1].sum),
                .dout   (sum)
            );
        end
    end

    if (L == 0) begin : g_no_tree
        assign tree_full = grp_cnt;
    end else begin : g_tree
        assign tree_full = g_lvl[L-1].sum;
    end

    // Valid shift register. Bit i lines up with the data after the popcount stage and i tree levels.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= valid_q;
            for (int i = 1; i <= L; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    // Output register. It loads only when valid and otherwise holds its previous value.
    // thresh_i is compared here directly rather than being carried down the pipeline.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_o      <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= vld_sr[L];
            if (vld_sr[L]) begin
                cnt_o      <= tree_full[CNT_W-1:0];
                overflow_o <= (CMP_W'(tree_full) > CMP_W'(thresh_i));
            end
        end
    end

    // A held overflow_o with valid_o low is not a new pulse.
    assign ovf_hit = valid_o && overflow_o;

    // Peak hold and saturating overflow tally, one cycle behind the outputs they observe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            peak_o    <= '0;
            ovf_cnt_o <= '0;
        end else begin
            if (clr_i) begin
                peak_o <= valid_o ? cnt_o : '0;
            end else if (valid_o && (cnt_o > peak_o)) begin
                peak_o <= cnt_o;
            end

            if (clr_i) begin
                ovf_cnt_o <= OVFCNT_W'(ovf_hit);
            end else if (ovf_hit && (ovf_cnt_o != '1)) begin
                ovf_cnt_o <= ovf_cnt_o + OVFCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cluster_count_pipe.sv
// Directed and randomised checks of cluster_count_pipe.
// Instance a uses the default 1536/6 configuration, with LAT = 11.
// Instance b uses 100/7 with a 4-bit tally: NGROUP = 15, so L = 4 and LAT = 7.
module tb_cluster_count_pipe;

    localparam int NA    = 1536;
    localparam int LAT_A = 11;
    localparam int CW_A  = 11;
    localparam int NB    = 100;
    localparam int GB    = 7;
    localparam int LAT_B = 7;
    localparam int CW_B  = 7;
    localparam int OW_B  = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic [NA-1:0]   vpfs_a = '0;
    logic            valid_a = 1'b0;
    logic [10:0]     thresh_a = '0;
    logic            clr_a = 1'b0;
    logic [CW_A-1:0] cnt_a;
    logic            vld_a;
    logic            ovf_a;
    logic [CW_A-1:0] peak_a;
    logic [15:0]     ovfc_a;

    logic [NB-1:0]   vpfs_b = '0;
    logic            valid_b = 1'b0;
    logic [10:0]     thresh_b = '0;
    logic            clr_b = 1'b0;
    logic [CW_B-1:0] cnt_b;
    logic            vld_b;
    logic            ovf_b;
    logic [CW_B-1:0] peak_b;
    logic [OW_B-1:0] ovfc_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state for the randomised test. Index 0 is instance a, index 1 is instance b.
    int p_cnt[2][16];
    bit p_vld[2][16];
    int m_cnt[2];
    bit m_vld[2];
    bit m_ovf[2];
    int m_peak[2];
    int m_ovfc[2];

    always #5 clock = ~clock;

    cluster_count_pipe u_dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .vpfs_i    (vpfs_a),
        .valid_i   (valid_a),
        .thresh_i  (thresh_a),
        .clr_i     (clr_a),
        .cnt_o     (cnt_a),
        .valid_o   (vld_a),
        .overflow_o(ovf_a),
        .peak_o    (peak_a),
        .ovf_cnt_o (ovfc_a)
    );

    cluster_count_pipe #(.NVPF(NB), .GROUP(GB), .THRESH_W(11), .OVFCNT_W(OW_B)) u_dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .vpfs_i    (vpfs_b),
        .valid_i   (valid_b),
        .thresh_i  (thresh_b),
        .clr_i     (clr_b),
        .cnt_o     (cnt_b),
        .valid_o   (vld_b),
        .overflow_o(ovf_b),
        .peak_o    (peak_b),
        .ovf_cnt_o (ovfc_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NA-1:0] ones_a(input int n);
        logic [NA-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                p_cnt[d][i] = 0;
                p_vld[d][i] = 1'b0;
            end
            m_cnt[d]  = 0;
            m_vld[d]  = 1'b0;
            m_ovf[d]  = 1'b0;
            m_peak[d] = 0;
            m_ovfc[d] = 0;
        end
    endtask

    // Advances the model by one clock using the inputs applied during the cycle that is ending.
    task automatic model_step(input int d, input int lat, input int in_cnt, input bit in_vld,
                              input int thr, input bit clr, input int sat);
        bit hit;
        hit = m_vld[d] && m_ovf[d];
        if (clr) m_peak[d] = m_vld[d] ? m_cnt[d] : 0;
        else if (m_vld[d] && m_cnt[d] > m_peak[d]) m_peak[d] = m_cnt[d];
        if (clr) m_ovfc[d] = hit ? 1 : 0;
        else if (hit && m_ovfc[d] < sat) m_ovfc[d] = m_ovfc[d] + 1;
        if (p_vld[d][lat-2]) begin
            m_cnt[d] = p_cnt[d][lat-2];
            m_ovf[d] = (p_cnt[d][lat-2] > thr);
        end
        m_vld[d] = p_vld[d][lat-2];
        for (int i = lat - 2; i > 0; i--) begin
            p_cnt[d][i] = p_cnt[d][i-1];
            p_vld[d][i] = p_vld[d][i-1];
        end
        p_cnt[d][0] = in_cnt;
        p_vld[d][0] = in_vld;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vpfs_a = '1; valid_a = 1'b1; vpfs_b = '1; valid_b = 1'b1;
        repeat (3) tick();
        n_vec++; if (cnt_a !== '0)  begin n_err++; $display("FAIL reset cnt_a: got %0d want 0", cnt_a); end
        n_vec++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL reset vld_a: got %0b want 0", vld_a); end
        n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL reset ovf_a: got %0b want 0", ovf_a); end
        n_vec++; if (peak_a !== '0) begin n_err++; $display("FAIL reset peak_a: got %0d want 0", peak_a); end
        n_vec++; if (ovfc_a !== '0) begin n_err++; $display("FAIL reset ovfc_a: got %0d want 0", ovfc_a); end
        n_vec++; if (cnt_b !== '0)  begin n_err++; $display("FAIL reset cnt_b: got %0d want 0", cnt_b); end
        n_vec++; if (vld_b !== 1'b0) begin n_err++; $display("FAIL reset vld_b: got %0b want 0", vld_b); end
        n_vec++; if (ovfc_b !== '0) begin n_err++; $display("FAIL reset ovfc_b: got %0d want 0", ovfc_b); end
        vpfs_a = '0; valid_a = 1'b0; vpfs_b = '0; valid_b = 1'b0;
        reset_n = 1'b1;
        for (int s = 1; s <= LAT_A + 1; s++) begin
            tick();
            n_vec++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL post_reset vld_a step %0d: got %0b want 0", s, vld_a); end
            n_vec++; if (vld_b !== 1'b0) begin n_err++; $display("FAIL post_reset vld_b step %0d: got %0b want 0", s, vld_b); end
        end
    endtask

    task automatic test_all_ones();
        vpfs_a = '1; valid_a = 1'b1; thresh_a = 11'd8;
        for (int s = 1; s <= LAT_A + 3; s++) begin
            tick();
            if (s == 1) begin vpfs_a = '0; valid_a = 1'b0; end
            n_vec++;
            if (vld_a !== 1'(s == LAT_A)) begin n_err++; $display("FAIL all_ones vld step %0d: got %0b want %0b", s, vld_a, s == LAT_A); end
            if (s == LAT_A) begin
                n_vec++; if (cnt_a !== CW_A'(1536)) begin n_err++; $display("FAIL all_ones cnt: got %0d want 1536", cnt_a); end
                n_vec++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL all_ones ovf: got %0b want 1", ovf_a); end
            end
            if (s == LAT_A + 1) begin
                n_vec++; if (peak_a !== CW_A'(1536)) begin n_err++; $display("FAIL all_ones peak: got %0d want 1536", peak_a); end
                n_vec++; if (ovfc_a !== 16'd1) begin n_err++; $display("FAIL all_ones ovfc: got %0d want 1", ovfc_a); end
            end
            if (s == LAT_A + 2) begin
                n_vec++; if (cnt_a !== CW_A'(1536)) begin n_err++; $display("FAIL all_ones cnt_hold: got %0d want 1536", cnt_a); end
            end
        end
    endtask

    task automatic test_threshold();
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        n_vec++; if (ovfc_a !== 16'd0) begin n_err++; $display("FAIL thresh clr ovfc: got %0d want 0", ovfc_a); end
        vpfs_a = ones_a(8); valid_a = 1'b1; thresh_a = 11'd8;
        for (int s = 1; s <= LAT_A + 3; s++) begin
            tick();
            if (s == 1) vpfs_a = ones_a(9);
            if (s == 2) begin vpfs_a = '0; valid_a = 1'b0; end
            if (s == LAT_A) begin
                n_vec++; if (vld_a !== 1'b1) begin n_err++; $display("FAIL thresh vld8: got %0b want 1", vld_a); end
                n_vec++; if (cnt_a !== CW_A'(8)) begin n_err++; $display("FAIL thresh cnt8: got %0d want 8", cnt_a); end
                n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL thresh ovf8: got %0b want 0", ovf_a); end
            end
            if (s == LAT_A + 1) begin
                n_vec++; if (cnt_a !== CW_A'(9)) begin n_err++; $display("FAIL thresh cnt9: got %0d want 9", cnt_a); end
                n_vec++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL thresh ovf9: got %0b want 1", ovf_a); end
                n_vec++; if (ovfc_a !== 16'd0) begin n_err++; $display("FAIL thresh ovfc_before: got %0d want 0", ovfc_a); end
            end
            if (s >= LAT_A + 2) begin
                n_vec++; if (ovfc_a !== 16'd1) begin n_err++; $display("FAIL thresh ovfc_after step %0d: got %0d want 1", s, ovfc_a); end
            end
        end
    endtask

    task automatic test_peak();
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        n_vec++; if (peak_a !== '0) begin n_err++; $display("FAIL peak clr: got %0d want 0", peak_a); end
        vpfs_a = ones_a(5); valid_a = 1'b1;
        for (int s = 1; s <= LAT_A + 3; s++) begin
            tick();
            if (s == 1) vpfs_a = ones_a(20);
            if (s == 2) vpfs_a = ones_a(7);
            if (s == 3) begin vpfs_a = '0; valid_a = 1'b0; end
            if (s == LAT_A + 1) begin
                n_vec++; if (peak_a !== CW_A'(5)) begin n_err++; $display("FAIL peak after5: got %0d want 5", peak_a); end
            end
            if (s == LAT_A + 2) begin
                n_vec++; if (peak_a !== CW_A'(20)) begin n_err++; $display("FAIL peak after20: got %0d want 20", peak_a); end
            end
            if (s == LAT_A + 3) begin
                n_vec++; if (peak_a !== CW_A'(20)) begin n_err++; $display("FAIL peak after7: got %0d want 20", peak_a); end
            end
        end
        vpfs_a = ones_a(3); valid_a = 1'b1;
        for (int s = 1; s <= LAT_A; s++) begin
            tick();
            if (s == 1) begin vpfs_a = '0; valid_a = 1'b0; end
        end
        n_vec++; if (cnt_a !== CW_A'(3)) begin n_err++; $display("FAIL peak cnt3: got %0d want 3", cnt_a); end
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        n_vec++; if (peak_a !== CW_A'(3)) begin n_err++; $display("FAIL peak clr_valid: got %0d want 3", peak_a); end
        n_vec++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL peak vld_low: got %0b want 0", vld_a); end
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        n_vec++; if (peak_a !== '0) begin n_err++; $display("FAIL peak clr_idle: got %0d want 0", peak_a); end
    endtask

    task automatic test_walking();
        logic exp_v;
        thresh_a = 11'd2047;
        for (int t = 0; t < NA + LAT_A; t++) begin
            vpfs_a = '0;
            valid_a = 1'b0;
            if (t < NA) begin
                vpfs_a[t] = 1'b1;
                valid_a = 1'b1;
            end
            tick();
            exp_v = ((t + 1) >= LAT_A) && ((t + 1) < LAT_A + NA);
            n_vec++; if (vld_a !== exp_v) begin n_err++; $display("FAIL walk vld step %0d: got %0b want %0b", t + 1, vld_a, exp_v); end
            if (exp_v) begin
                n_vec++; if (cnt_a !== CW_A'(1)) begin n_err++; $display("FAIL walk cnt bit %0d: got %0d want 1", t + 1 - LAT_A, cnt_a); end
            end
        end
        vpfs_a = '0; valid_a = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_c;
        thresh_b = 11'd0;
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        for (int s = 1; s <= LAT_B + 21; s++) begin
            vpfs_b = '0; valid_b = 1'b0;
            if (s <= 20) begin vpfs_b[0] = 1'b1; valid_b = 1'b1; end
            tick();
            if (s >= LAT_B) begin
                exp_c = (s - LAT_B < 15) ? s - LAT_B : 15;
                n_vec++; if (ovfc_b !== OW_B'(exp_c)) begin n_err++; $display("FAIL sat ovfc step %0d: got %0d want %0d", s, ovfc_b, exp_c); end
            end
            if (s >= LAT_B && s < LAT_B + 20) begin
                n_vec++; if (ovf_b !== 1'b1 || vld_b !== 1'b1) begin n_err++; $display("FAIL sat pulse step %0d: got ovf=%0b vld=%0b want 1 1", s, ovf_b, vld_b); end
            end
        end
        vpfs_b = '0; valid_b = 1'b0;
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        n_vec++; if (ovfc_b !== '0) begin n_err++; $display("FAIL sat clr_idle: got %0d want 0", ovfc_b); end
        vpfs_b[0] = 1'b1; valid_b = 1'b1;
        for (int s = 1; s <= LAT_B; s++) begin
            tick();
            if (s == 1) begin vpfs_b = '0; valid_b = 1'b0; end
        end
        n_vec++; if (ovf_b !== 1'b1 || vld_b !== 1'b1) begin n_err++; $display("FAIL sat coinc_pulse: got ovf=%0b vld=%0b want 1 1", ovf_b, vld_b); end
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        n_vec++; if (ovfc_b !== OW_B'(1)) begin n_err++; $display("FAIL sat clr_coinc: got %0d want 1", ovfc_b); end
    endtask

    task automatic test_random();
        int mode;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        thresh_a = 11'd768;
        thresh_b = 11'd50;
        for (int cyc = 0; cyc < 400; cyc++) begin
            mode = $urandom_range(0, 7);
            if (mode == 0) vpfs_a = '0;
            else if (mode == 1) vpfs_a = '1;
            else for (int w = 0; w < NA / 32; w++) vpfs_a[w*32 +: 32] = $urandom;
            valid_a = ($urandom_range(0, 3) != 0);
            clr_a = ($urandom_range(0, 15) == 0);
            mode = $urandom_range(0, 7);
            if (mode == 0) vpfs_b = '0;
            else if (mode == 1) vpfs_b = '1;
            else vpfs_b = NB'({$urandom, $urandom, $urandom, $urandom});
            valid_b = ($urandom_range(0, 3) != 0);
            clr_b = ($urandom_range(0, 15) == 0);
            if (cyc == 200) begin
                reset_n = 1'b0;
                #2;
                n_vec++; if (cnt_a !== '0 || vld_a !== 1'b0 || ovf_a !== 1'b0 || peak_a !== '0 || ovfc_a !== '0) begin
                    n_err++; $display("FAIL async_reset a: got cnt=%0d vld=%0b ovf=%0b peak=%0d ovfc=%0d want all 0", cnt_a, vld_a, ovf_a, peak_a, ovfc_a);
                end
                n_vec++; if (cnt_b !== '0 || vld_b !== 1'b0 || ovf_b !== 1'b0 || peak_b !== '0 || ovfc_b !== '0) begin
                    n_err++; $display("FAIL async_reset b: got cnt=%0d vld=%0b ovf=%0b peak=%0d ovfc=%0d want all 0", cnt_b, vld_b, ovf_b, peak_b, ovfc_b);
                end
                tick();
                reset_n = 1'b1;
                model_reset();
                continue;
            end
            model_step(0, LAT_A, $countones(vpfs_a), valid_a, int'(thresh_a), clr_a, 65535);
            model_step(1, LAT_B, $countones(vpfs_b), valid_b, int'(thresh_b), clr_b, 15);
            tick();
            n_vec++; if (vld_a !== m_vld[0]) begin n_err++; $display("FAIL rand vld_a cyc %0d: got %0b want %0b", cyc, vld_a, m_vld[0]); end
            n_vec++; if (cnt_a !== CW_A'(m_cnt[0])) begin n_err++; $display("FAIL rand cnt_a cyc %0d: got %0d want %0d", cyc, cnt_a, m_cnt[0]); end
            n_vec++; if (ovf_a !== m_ovf[0]) begin n_err++; $display("FAIL rand ovf_a cyc %0d: got %0b want %0b", cyc, ovf_a, m_ovf[0]); end
            n_vec++; if (peak_a !== CW_A'(m_peak[0])) begin n_err++; $display("FAIL rand peak_a cyc %0d: got %0d want %0d", cyc, peak_a, m_peak[0]); end
            n_vec++; if (ovfc_a !== 16'(m_ovfc[0])) begin n_err++; $display("FAIL rand ovfc_a cyc %0d: got %0d want %0d", cyc, ovfc_a, m_ovfc[0]); end
            n_vec++; if (vld_b !== m_vld[1]) begin n_err++; $display("FAIL rand vld_b cyc %0d: got %0b want %0b", cyc, vld_b, m_vld[1]); end
            n_vec++; if (cnt_b !== CW_B'(m_cnt[1])) begin n_err++; $display("FAIL rand cnt_b cyc %0d: got %0d want %0d", cyc, cnt_b, m_cnt[1]); end
            n_vec++; if (ovf_b !== m_ovf[1]) begin n_err++; $display("FAIL rand ovf_b cyc %0d: got %0b want %0b", cyc, ovf_b, m_ovf[1]); end
            n_vec++; if (peak_b !== CW_B'(m_peak[1])) begin n_err++; $display("FAIL rand peak_b cyc %0d: got %0d want %0d", cyc, peak_b, m_peak[1]); end
            n_vec++; if (ovfc_b !== OW_B'(m_ovfc[1])) begin n_err++; $display("FAIL rand ovfc_b cyc %0d: got %0d want %0d", cyc, ovfc_b, m_ovfc[1]); end
        end
        vpfs_a = '0; valid_a = 1'b0; clr_a = 1'b0;
        vpfs_b = '0; valid_b = 1'b0; clr_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_threshold();
        test_peak();
        test_walking();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
